// File: rtl/sha256_core_if.sv
// Register-bus bundle for the SHA-256 core: single-cycle word accesses
// with combinational read data and access-error flag.
interface sha256_core_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        error;

  modport master (output cs, we, address, write_data, input read_data, error);
  modport slave  (input cs, we, address, write_data, output read_data, error);
endinterface

// File: rtl/sha256_core.sv
// SHA-256 compression engine behind a 32-bit register map: one round per
// clock over a latched 16-word block, digest accumulated in H on completion.
module sha256_core (
  input  logic           clk,
  input  logic           reset_n,
  sha256_core_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ROUNDS, DONE} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic        ready_q, ready_d, valid_q, valid_d;
  logic        init_q, init_d, next_q, next_d;
  logic [31:0] block_q [16];
  logic [31:0] h_q [8], h_d [8];
  logic [31:0] v_q [8], v_d [8];
  logic [31:0] w_q [16], w_d [16];

  logic        wr, rd, ctrl_wr, blk_wr, legal_rd, legal_wr;
  logic [31:0] rdata;

  assign wr      = bus.cs & bus.we;
  assign rd      = bus.cs & ~bus.we;
  assign ctrl_wr = wr & (bus.address == 8'h08);
  assign blk_wr  = wr & (bus.address[7:4] == 4'h1);

  always_comb begin
    rdata    = '0;
    legal_rd = 1'b0;
    legal_wr = 1'b0;
    if (bus.address == 8'h00) begin
      legal_rd = 1'b1; rdata = 32'h73686132;
    end else if (bus.address == 8'h01) begin
      legal_rd = 1'b1; rdata = 32'h2d323536;
    end else if (bus.address == 8'h02) begin
      legal_rd = 1'b1; rdata = 32'h302e3830;
    end else if (bus.address == 8'h08) begin
      legal_wr = 1'b1;
    end else if (bus.address == 8'h09) begin
      legal_rd = 1'b1; rdata = {30'd0, valid_q, ready_q};
    end else if (bus.address[7:4] == 4'h1) begin
      legal_rd = 1'b1; legal_wr = 1'b1; rdata = block_q[bus.address[3:0]];
    end else if (bus.address[7:3] == 5'b00100) begin
      legal_rd = 1'b1; rdata = h_q[bus.address[2:0]];
    end
  end

  assign bus.error     = bus.cs & (bus.we ? ~legal_wr : ~legal_rd);
  assign bus.read_data = (rd & legal_rd) ? rdata : '0;

  logic [31:0] t1, t2, w_new;
  assign t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
            + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[t_q] + w_q[0];
  assign t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
            + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  assign w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
               + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ready_d = ready_q;
    valid_d = valid_q;
    init_d  = 1'b0;
    next_d  = 1'b0;
    h_d     = h_q;
    v_d     = v_q;
    w_d     = w_q;
    // Start requests are only honoured while ready; ready drops on the capturing edge.
    if (ctrl_wr && ready_q && (bus.write_data[0] || bus.write_data[1])) begin
      init_d  = bus.write_data[0];
      next_d  = ~bus.write_data[0];
      ready_d = 1'b0;
      valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (init_q || next_q) begin
          for (int i = 0; i < 8; i++) begin
            v_d[i] = init_q ? H_INIT[i] : h_q[i];
            if (init_q) h_d[i] = H_INIT[i];
          end
          w_d     = block_q;
          t_d     = 6'd0;
          state_d = ROUNDS;
        end
      end
      ROUNDS: begin
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
        w_d[15] = w_new;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) state_d = DONE;
      end
      DONE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
        ready_d = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      for (int i = 0; i < 16; i++) block_q[i] <= '0;
      for (int i = 0; i < 8; i++)  h_q[i]     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      init_q  <= init_d;
      next_q  <= next_d;
      if (blk_wr) block_q[bus.address[3:0]] <= bus.write_data;
      h_q <= h_d;
    end
  end

  // Working variables and message schedule carry no reset; they are loaded at start.
  always_ff @(posedge clk) begin
    v_q <= v_d;
    w_q <= w_d;
  end
endmodule

// File: tb/tb_sha256_core.sv
// Directed bench for sha256_core: expected bus responses are queued as each
// access is issued and popped when the combinational response is sampled.
module tb_sha256_core;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sha256_core_if bus ();
  sha256_core dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct { string tag; logic [31:0] data; logic err; } exp_t;
  exp_t sb [$];
  int ncomp = 0;
  int nfail = 0;

  localparam logic [31:0] ABC_BLK [16] = '{
    32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018 };
  localparam logic [31:0] ABC_DIG [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad };
  localparam logic [31:0] M1 [16] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000 };
  localparam logic [31:0] M2 [16] = '{
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0 };
  localparam logic [31:0] M_DIG [8] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1 };
  localparam logic [31:0] ZERO_DIG [8] = '{default: 32'h0};

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    ncomp++;
    assert (bus.read_data === e.data) else begin
      nfail++;
      $error("FAIL %s data: observed %h expected %h", e.tag, bus.read_data, e.data);
    end
    ncomp++;
    assert (bus.error === e.err) else begin
      nfail++;
      $error("FAIL %s error: observed %b expected %b", e.tag, bus.error, e.err);
    end
  endtask

  // Each access starts at a negedge and returns at the following negedge.
  task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic ee, input string tag);
    exp_t e;
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
    e.tag = tag; e.data = ed; e.err = ee;
    sb.push_back(e);
    #1 check_out();
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic wr_err(input logic [7:0] a, input logic [31:0] d, input string tag);
    exp_t e;
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
    e.tag = tag; e.data = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    #1 check_out();
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_block(input logic [31:0] b [16]);
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), b[i]);
  endtask

  task automatic wait_ready(output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      bus.cs = 1'b1; bus.we = 1'b0; bus.address = 8'h09;
      #1 got = bus.read_data[0];
      n++;
      @(negedge clk);
    end
    bus.cs = 1'b0;
    ncomp++;
    assert (got === 1'b1) else begin
      nfail++;
      $error("FAIL ready_timeout: observed %b expected %b", got, 1'b1);
    end
  endtask

  task automatic check_digest(input logic [31:0] d [8], input string tag);
    for (int i = 0; i < 8; i++)
      rd(8'(8'h20 + i), d[i], 1'b0, $sformatf("%s_dig%0d", tag, i));
  endtask

  initial begin
    int n;
    bus.cs = 1'b0; bus.we = 1'b0; bus.address = 8'h00; bus.write_data = 32'h0;
    reset_n = 1'b1;
    nop(3);
    reset_n = 1'b0;

    // Reset state and identification registers.
    rd(8'h09, 32'h00000001, 1'b0, "rst_status");
    check_digest(ZERO_DIG, "rst");
    rd(8'h00, 32'h73686132, 1'b0, "name0");
    rd(8'h01, 32'h2d323536, 1'b0, "name1");
    rd(8'h02, 32'h302e3830, 1'b0, "version");

    // Single block "abc".
    load_block(ABC_BLK);
    rd(8'h10, 32'h61626380, 1'b0, "block0_rb");
    wr(8'h08, 32'h1);
    wait_ready(n);
    rd(8'h09, 32'h00000003, 1'b0, "abc_status");
    check_digest(ABC_DIG, "abc");

    // Exact latency: busy for cycles 1..65, ready and valid at cycle 66.
    wr(8'h08, 32'h1);
    nop(1);
    for (int k = 1; k <= 66; k++)
      rd(8'h09, (k == 66) ? 32'h3 : 32'h0, 1'b0, $sformatf("lat_c%0d", k));
    check_digest(ABC_DIG, "lat");

    // Second init (init+next both set) mid-run must be ignored: completion stays at cycle 66.
    wr(8'h08, 32'h1);
    nop(10);
    wr(8'h08, 32'h3);
    wait_ready(n);
    ncomp++;
    assert (n === 56) else begin
      nfail++;
      $error("FAIL ignored_init_polls: observed %0d expected %0d", n, 56);
    end
    check_digest(ABC_DIG, "ign");

    // Two-block message.
    load_block(M1);
    wr(8'h08, 32'h1);
    wait_ready(n);
    load_block(M2);
    wr(8'h08, 32'h2);
    wait_ready(n);
    rd(8'h09, 32'h00000003, 1'b0, "two_status");
    check_digest(M_DIG, "two");

    // Illegal accesses.
    wr_err(8'h20, 32'hdeadbeef, "wr_digest");
    rd(8'h20, M_DIG[0], 1'b0, "digest_unchanged");
    rd(8'h30, 32'h0, 1'b1, "rd_unmapped");
    rd(8'h08, 32'h0, 1'b1, "rd_ctrl");
    wr_err(8'h09, 32'h0, "wr_status");

    // Reset in the middle of a run.
    load_block(ABC_BLK);
    wr(8'h08, 32'h1);
    nop(30);
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    rd(8'h09, 32'h00000001, 1'b0, "midrst_status");
    check_digest(ZERO_DIG, "midrst");
    rd(8'h10, 32'h0, 1'b0, "midrst_block0");

    // Fresh run after the abort.
    load_block(ABC_BLK);
    wr(8'h08, 32'h1);
    wait_ready(n);
    check_digest(ABC_DIG, "fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
